// File: rtl/capi_put_cmd_issue_pkg.sv
// ---------------------------------------------------------------------------
// capi_put_cmd_issue_pkg
//   Shared definitions for the put128 PSL command issue slice.
//   Holds the PSL command and response codes, the field widths of the
//   encoder FIFO entry and the PSL command bus, the credit counter type,
//   and the helper that builds the PSL size field from a transfer size.
// ---------------------------------------------------------------------------
package capi_put_cmd_issue_pkg;

    // PSL command opcodes used by this slice
    localparam logic [12:0] PSL_CMD_WRITE_MI = 13'h0D00;

    // PSL response codes (anything other than DONE is a failure)
    localparam logic [7:0]  PSL_RSP_DONE     = 8'h00;

    // Field widths
    localparam int ENG_TAG_W  = 5;
    localparam int TSIZE_W    = 10;
    localparam int SIZE_W     = 12;
    localparam int AUX_W      = 11;
    localparam int CTXT_W     = 10;
    localparam int RSP_CODE_W = 8;
    localparam int CRED_W     = 8;

    typedef logic [CRED_W-1:0] credit_t;

    // PSL size field is the byte count zero-extended to 12 bits
    function automatic logic [SIZE_W-1:0] psl_size(input logic [TSIZE_W-1:0] tsize);
        return {2'b00, tsize};
    endfunction

endpackage

// File: rtl/capi_tag_alloc.sv
// ---------------------------------------------------------------------------
// capi_tag_alloc
//   PSL tag free-list. Keeps a free bitmap, offers the lowest-index free tag
//   every cycle, and updates the map on alloc/free at the clock edge.
//   Allocation always looks at the pre-edge map, so a tag freed in the same
//   cycle becomes available only on the following cycle.
// Ports
//   clk, reset   clock, asynchronous active-low reset (all tags free)
//   alloc        take alloc_tag at this edge
//   free_v       release free_tag at this edge
//   free_tag     tag being released
//   alloc_tag    lowest-index free tag (valid when any_free)
//   any_free     at least one tag free
//   all_free     every tag free
//   busy         per-tag in-use map
// ---------------------------------------------------------------------------
module capi_tag_alloc #(
    parameter int tag_width = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      alloc,
    input  logic                      free_v,
    input  logic [tag_width-1:0]      free_tag,
    output logic [tag_width-1:0]      alloc_tag,
    output logic                      any_free,
    output logic                      all_free,
    output logic [(2**tag_width)-1:0] busy
);

    localparam int depth = 2**tag_width;

    logic [depth-1:0]     free_r;
    logic [depth-1:0]     free_next_s;
    logic [depth-1:0]     alloc_oh_s;
    logic [depth-1:0]     free_oh_s;
    logic [tag_width-1:0] alloc_tag_s;

    // Lowest-index priority encoder over the free map (scan high to low, last hit wins)
    always_comb begin
        alloc_tag_s = {tag_width{1'b0}};
        for (int i = depth - 1; i >= 0; i--) begin
            if (free_r[i]) begin
                alloc_tag_s = tag_width'(i);
            end else begin
                alloc_tag_s = alloc_tag_s;
            end
        end
    end

    // Next free map: clear the allocated bit, set the released bit
    always_comb begin
        alloc_oh_s  = alloc  ? ({{(depth-1){1'b0}}, 1'b1} << alloc_tag_s) : {depth{1'b0}};
        free_oh_s   = free_v ? ({{(depth-1){1'b0}}, 1'b1} << free_tag)    : {depth{1'b0}};
        free_next_s = (free_r & ~alloc_oh_s) | free_oh_s;
    end

    // Free map register; every tag free out of reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            free_r <= {depth{1'b1}};
        end else begin
            free_r <= free_next_s;
        end
    end

    assign alloc_tag = alloc_tag_s;
    assign any_free  = |free_r;
    assign all_free  = &free_r;
    assign busy      = ~free_r;

endmodule

// File: rtl/capi_put_cmd_issue.sv
// ---------------------------------------------------------------------------
// capi_put_cmd_issue
//   Pops encoded write commands from the put128 encoder FIFO, allocates a
//   PSL tag, and issues one write_mi command per entry. Tracks PSL command
//   credits and outstanding tags, maps PSL responses back to the engine tag
//   and reports completion upstream.
// Ports
//   clk, reset         clock, asynchronous active-low reset
//   i_cmd_*/o_cmd_r    encoder FIFO entry and pop (pop = i_cmd_v & o_cmd_r)
//   o_psl_cmd_*        PSL command bus, one-cycle valid, latency 1 from pop
//   i_rsp_*            PSL response; each response returns one credit
//   o_done_*           completion pulse to the engine, latency 1 from response
//   o_idle             no tags outstanding and all credits home
//   o_err_unexp_rsp    sticky: response arrived on a tag not in use
// ---------------------------------------------------------------------------
module capi_put_cmd_issue
    import capi_put_cmd_issue_pkg::*;
#(
    parameter int          ea_width     = 65,
    parameter int          sid_width    = 3,
    parameter int          tag_width    = 5,
    parameter int          init_credits = 32,
    parameter logic [12:0] cmd_code     = PSL_CMD_WRITE_MI
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_cmd_v,
    output logic                  o_cmd_r,
    input  logic [ENG_TAG_W-1:0]  i_cmd_tag,
    input  logic [TSIZE_W-1:0]    i_cmd_tsize,
    input  logic [ea_width-1:0]   i_cmd_ea,
    input  logic [sid_width-1:0]  i_cmd_sid,
    input  logic                  i_cmd_f,
    input  logic [AUX_W-1:0]      i_cmd_aux,
    input  logic [CTXT_W-1:0]     i_cmd_ctxt,
    output logic                  o_psl_cmd_v,
    output logic [tag_width-1:0]  o_psl_cmd_tag,
    output logic [12:0]           o_psl_cmd_code,
    output logic [ea_width-1:0]   o_psl_cmd_ea,
    output logic [SIZE_W-1:0]     o_psl_cmd_size,
    output logic [AUX_W-1:0]      o_psl_cmd_aux,
    output logic [CTXT_W-1:0]     o_psl_cmd_ctxt,
    input  logic                  i_rsp_v,
    input  logic [tag_width-1:0]  i_rsp_tag,
    input  logic [RSP_CODE_W-1:0] i_rsp_code,
    output logic                  o_done_v,
    output logic [ENG_TAG_W-1:0]  o_done_tag,
    output logic [sid_width-1:0]  o_done_sid,
    output logic                  o_done_f,
    output logic                  o_done_ok,
    output logic                  o_idle,
    output logic                  o_err_unexp_rsp
);

    localparam int      depth       = 2**tag_width;
    localparam int      ent_w       = ENG_TAG_W + sid_width + 1;
    localparam credit_t init_cred_c = CRED_W'(init_credits);

    // Tag allocator interface
    logic                 pop_s;
    logic                 any_free_s;
    logic                 all_free_s;
    logic [depth-1:0]     busy_s;
    logic [tag_width-1:0] alloc_tag_s;

    // Response decode
    logic                 rsp_hit_s;
    logic                 rsp_unexp_s;
    logic [ent_w-1:0]     rsp_ent_s;

    // Credit tracking
    logic                 cred_inc_s;
    credit_t              credits_next_s;
    credit_t              credits_r;
    logic                 err_r;

    // Tag table: engine tag, stream id and flag per PSL tag
    logic [ent_w-1:0]     table_r [depth];

    // Issue output register
    logic                  cmd_v_r;
    logic [tag_width-1:0]  cmd_tag_r;
    logic [12:0]           cmd_code_r;
    logic [ea_width-1:0]   cmd_ea_r;
    logic [SIZE_W-1:0]     cmd_size_r;
    logic [AUX_W-1:0]      cmd_aux_r;
    logic [CTXT_W-1:0]     cmd_ctxt_r;

    // Completion output register
    logic                  done_v_r;
    logic [ENG_TAG_W-1:0]  done_tag_r;
    logic [sid_width-1:0]  done_sid_r;
    logic                  done_f_r;
    logic                  done_ok_r;

    capi_tag_alloc #(
        .tag_width (tag_width)
    ) u_tag_alloc (
        .clk       (clk),
        .reset     (reset),
        .alloc     (pop_s),
        .free_v    (rsp_hit_s),
        .free_tag  (i_rsp_tag),
        .alloc_tag (alloc_tag_s),
        .any_free  (any_free_s),
        .all_free  (all_free_s),
        .busy      (busy_s)
    );

    // Pop decision depends only on the FIFO valid and registered state, never on i_rsp_*
    always_comb begin
        pop_s = i_cmd_v & (credits_r != {CRED_W{1'b0}}) & any_free_s;
    end

    // Response decode against the pre-edge busy map
    always_comb begin
        rsp_hit_s   = i_rsp_v &  busy_s[i_rsp_tag];
        rsp_unexp_s = i_rsp_v & ~busy_s[i_rsp_tag];
        rsp_ent_s   = table_r[i_rsp_tag];
    end

    // Credit next state: a return is dropped only when the counter is already
    // full and nothing is being issued this cycle (saturation at init_credits)
    always_comb begin
        cred_inc_s = i_rsp_v & ((credits_r != init_cred_c) | pop_s);
        case ({cred_inc_s, pop_s})
            2'b10:   credits_next_s = credits_r + {{(CRED_W-1){1'b0}}, 1'b1};
            2'b01:   credits_next_s = credits_r - {{(CRED_W-1){1'b0}}, 1'b1};
            default: credits_next_s = credits_r;
        endcase
    end

    // Credit counter and sticky unexpected-response flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credits_r <= init_cred_c;
            err_r     <= 1'b0;
        end else begin
            credits_r <= credits_next_s;
            err_r     <= err_r | rsp_unexp_s;
        end
    end

    // Tag table write on every pop at the allocated tag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < depth; i++) begin
                table_r[i] <= {ent_w{1'b0}};
            end
        end else if (pop_s) begin
            table_r[alloc_tag_s] <= {i_cmd_tag, i_cmd_sid, i_cmd_f};
        end else begin
            table_r[alloc_tag_s] <= table_r[alloc_tag_s];
        end
    end

    // PSL command output register, loaded on pop, valid for exactly one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_v_r    <= 1'b0;
            cmd_tag_r  <= {tag_width{1'b0}};
            cmd_code_r <= 13'h0000;
            cmd_ea_r   <= {ea_width{1'b0}};
            cmd_size_r <= {SIZE_W{1'b0}};
            cmd_aux_r  <= {AUX_W{1'b0}};
            cmd_ctxt_r <= {CTXT_W{1'b0}};
        end else begin
            cmd_v_r <= pop_s;
            if (pop_s) begin
                cmd_tag_r  <= alloc_tag_s;
                cmd_code_r <= cmd_code;
                cmd_ea_r   <= i_cmd_ea;
                cmd_size_r <= psl_size(i_cmd_tsize);
                cmd_aux_r  <= i_cmd_aux;
                cmd_ctxt_r <= i_cmd_ctxt;
            end else begin
                cmd_tag_r  <= cmd_tag_r;
                cmd_code_r <= cmd_code_r;
                cmd_ea_r   <= cmd_ea_r;
                cmd_size_r <= cmd_size_r;
                cmd_aux_r  <= cmd_aux_r;
                cmd_ctxt_r <= cmd_ctxt_r;
            end
        end
    end

    // Completion output register, loaded only for responses on busy tags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_v_r   <= 1'b0;
            done_tag_r <= {ENG_TAG_W{1'b0}};
            done_sid_r <= {sid_width{1'b0}};
            done_f_r   <= 1'b0;
            done_ok_r  <= 1'b0;
        end else begin
            done_v_r <= rsp_hit_s;
            if (rsp_hit_s) begin
                done_tag_r <= rsp_ent_s[ent_w-1 -: ENG_TAG_W];
                done_sid_r <= rsp_ent_s[sid_width:1];
                done_f_r   <= rsp_ent_s[0];
                done_ok_r  <= (i_rsp_code == PSL_RSP_DONE);
            end else begin
                done_tag_r <= done_tag_r;
                done_sid_r <= done_sid_r;
                done_f_r   <= done_f_r;
                done_ok_r  <= done_ok_r;
            end
        end
    end

    assign o_cmd_r         = pop_s;
    assign o_psl_cmd_v     = cmd_v_r;
    assign o_psl_cmd_tag   = cmd_tag_r;
    assign o_psl_cmd_code  = cmd_code_r;
    assign o_psl_cmd_ea    = cmd_ea_r;
    assign o_psl_cmd_size  = cmd_size_r;
    assign o_psl_cmd_aux   = cmd_aux_r;
    assign o_psl_cmd_ctxt  = cmd_ctxt_r;
    assign o_done_v        = done_v_r;
    assign o_done_tag      = done_tag_r;
    assign o_done_sid      = done_sid_r;
    assign o_done_f        = done_f_r;
    assign o_done_ok       = done_ok_r;
    // Idle is derived from registered state only
    assign o_idle          = all_free_s & (credits_r == init_cred_c);
    assign o_err_unexp_rsp = err_r;

endmodule

// File: tb/tb_capi_put_cmd_issue.sv
// ---------------------------------------------------------------------------
// tb_capi_put_cmd_issue
//   Directed bench. dut: 32 tags, 4 credits (credit-limited).
//   dut2: 2 tags, 4 credits (tag-limited). Both share clock and reset.
// ---------------------------------------------------------------------------
module tb_capi_put_cmd_issue;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_cmd_v = 1'b0;
    logic [4:0]  i_cmd_tag = 5'd0;
    logic [9:0]  i_cmd_tsize = 10'd0;
    logic [64:0] i_cmd_ea = 65'd0;
    logic [2:0]  i_cmd_sid = 3'd0;
    logic        i_cmd_f = 1'b0;
    logic [10:0] i_cmd_aux = 11'h5A5;
    logic [9:0]  i_cmd_ctxt = 10'h2C3;
    logic        i_rsp_v = 1'b0;
    logic [4:0]  i_rsp_tag = 5'd0;
    logic [7:0]  i_rsp_code = 8'd0;

    logic        o_cmd_r, o_psl_cmd_v, o_done_v, o_done_f, o_done_ok, o_idle, o_err_unexp_rsp;
    logic [4:0]  o_psl_cmd_tag, o_done_tag;
    logic [12:0] o_psl_cmd_code;
    logic [64:0] o_psl_cmd_ea;
    logic [11:0] o_psl_cmd_size;
    logic [10:0] o_psl_cmd_aux;
    logic [9:0]  o_psl_cmd_ctxt;
    logic [2:0]  o_done_sid;

    // second instance signals
    logic        c2_v = 1'b0;
    logic        r2_v = 1'b0;
    logic [0:0]  r2_tag = 1'b0;
    logic        b_cmd_r, b_cmd_v, b_done_v, b_done_f, b_done_ok, b_idle, b_err;
    logic [0:0]  b_cmd_tag;
    logic [12:0] b_code;
    logic [64:0] b_ea;
    logic [11:0] b_size;
    logic [10:0] b_aux;
    logic [9:0]  b_ctxt;
    logic [4:0]  b_done_tag;
    logic [2:0]  b_done_sid;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    capi_put_cmd_issue #(
        .ea_width(65), .sid_width(3), .tag_width(5), .init_credits(4), .cmd_code(13'h0D00)
    ) dut (
        .clk(clk), .reset(reset),
        .i_cmd_v(i_cmd_v), .o_cmd_r(o_cmd_r), .i_cmd_tag(i_cmd_tag), .i_cmd_tsize(i_cmd_tsize),
        .i_cmd_ea(i_cmd_ea), .i_cmd_sid(i_cmd_sid), .i_cmd_f(i_cmd_f), .i_cmd_aux(i_cmd_aux),
        .i_cmd_ctxt(i_cmd_ctxt),
        .o_psl_cmd_v(o_psl_cmd_v), .o_psl_cmd_tag(o_psl_cmd_tag), .o_psl_cmd_code(o_psl_cmd_code),
        .o_psl_cmd_ea(o_psl_cmd_ea), .o_psl_cmd_size(o_psl_cmd_size), .o_psl_cmd_aux(o_psl_cmd_aux),
        .o_psl_cmd_ctxt(o_psl_cmd_ctxt),
        .i_rsp_v(i_rsp_v), .i_rsp_tag(i_rsp_tag), .i_rsp_code(i_rsp_code),
        .o_done_v(o_done_v), .o_done_tag(o_done_tag), .o_done_sid(o_done_sid), .o_done_f(o_done_f),
        .o_done_ok(o_done_ok), .o_idle(o_idle), .o_err_unexp_rsp(o_err_unexp_rsp)
    );

    capi_put_cmd_issue #(
        .ea_width(65), .sid_width(3), .tag_width(1), .init_credits(4), .cmd_code(13'h0D00)
    ) dut2 (
        .clk(clk), .reset(reset),
        .i_cmd_v(c2_v), .o_cmd_r(b_cmd_r), .i_cmd_tag(i_cmd_tag), .i_cmd_tsize(i_cmd_tsize),
        .i_cmd_ea(i_cmd_ea), .i_cmd_sid(i_cmd_sid), .i_cmd_f(i_cmd_f), .i_cmd_aux(i_cmd_aux),
        .i_cmd_ctxt(i_cmd_ctxt),
        .o_psl_cmd_v(b_cmd_v), .o_psl_cmd_tag(b_cmd_tag), .o_psl_cmd_code(b_code),
        .o_psl_cmd_ea(b_ea), .o_psl_cmd_size(b_size), .o_psl_cmd_aux(b_aux),
        .o_psl_cmd_ctxt(b_ctxt),
        .i_rsp_v(r2_v), .i_rsp_tag(r2_tag), .i_rsp_code(i_rsp_code),
        .o_done_v(b_done_v), .o_done_tag(b_done_tag), .o_done_sid(b_done_sid), .o_done_f(b_done_f),
        .o_done_ok(b_done_ok), .o_idle(b_idle), .o_err_unexp_rsp(b_err)
    );

    // Present one FIFO entry for one cycle; report pop and the issued command.
    // Called and returns #1 after a rising edge.
    task automatic do_issue(input logic [4:0] etag, input logic [9:0] tsz, input logic [64:0] ea,
                            output logic got_r, output logic got_v, output logic [4:0] got_ptag);
        i_cmd_v = 1'b1; i_cmd_tag = etag; i_cmd_tsize = tsz; i_cmd_ea = ea;
        i_cmd_sid = etag[2:0]; i_cmd_f = etag[0];
        #1 got_r = o_cmd_r;
        @(posedge clk); #1;
        i_cmd_v = 1'b0;
        got_v = o_psl_cmd_v; got_ptag = o_psl_cmd_tag;
    endtask

    // Present one PSL response for one cycle; report the completion outputs.
    task automatic do_rsp(input logic [4:0] tag, input logic [7:0] code,
                          output logic dv, output logic [4:0] dtag, output logic dok);
        i_rsp_v = 1'b1; i_rsp_tag = tag; i_rsp_code = code;
        @(posedge clk); #1;
        i_rsp_v = 1'b0;
        dv = o_done_v; dtag = o_done_tag; dok = o_done_ok;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (o_psl_cmd_v !== 1'b0 || o_done_v !== 1'b0) begin failures++; $display("FAIL rst_valids got=%b%b exp=00", o_psl_cmd_v, o_done_v); end
        checks++; if (o_idle !== 1'b1) begin failures++; $display("FAIL rst_idle got=%b exp=1", o_idle); end
        checks++; if (o_err_unexp_rsp !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", o_err_unexp_rsp); end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (o_idle !== 1'b1 || o_cmd_r !== 1'b0) begin failures++; $display("FAIL rst_post got idle=%b cmd_r=%b exp 1 0", o_idle, o_cmd_r); end
    endtask

    task automatic test_single();
        logic r, v, dv, dok; logic [4:0] pt, dt;
        do_issue(5'h03, 10'd128, 65'h1000, r, v, pt);
        checks++; if (r !== 1'b1) begin failures++; $display("FAIL t1_pop got=%b exp=1", r); end
        checks++; if (v !== 1'b1 || pt !== 5'd0) begin failures++; $display("FAIL t1_issue got v=%b tag=%0d exp v=1 tag=0", v, pt); end
        checks++; if (o_psl_cmd_size !== 12'h080 || o_psl_cmd_ea !== 65'h1000 || o_psl_cmd_code !== 13'h0D00)
            begin failures++; $display("FAIL t1_fields got size=%h ea=%h code=%h exp 080 1000 0d00", o_psl_cmd_size, o_psl_cmd_ea, o_psl_cmd_code); end
        checks++; if (o_psl_cmd_aux !== 11'h5A5 || o_psl_cmd_ctxt !== 10'h2C3) begin failures++; $display("FAIL t1_pass got aux=%h ctxt=%h exp 5a5 2c3", o_psl_cmd_aux, o_psl_cmd_ctxt); end
        checks++; if (o_idle !== 1'b0) begin failures++; $display("FAIL t1_busy_idle got=%b exp=0", o_idle); end
        @(posedge clk); #1;
        checks++; if (o_psl_cmd_v !== 1'b0) begin failures++; $display("FAIL t1_one_cycle got=%b exp=0", o_psl_cmd_v); end
        do_rsp(5'd0, 8'h00, dv, dt, dok);
        checks++; if (dv !== 1'b1 || dt !== 5'h03 || dok !== 1'b1) begin failures++; $display("FAIL t1_done got v=%b tag=%h ok=%b exp 1 03 1", dv, dt, dok); end
        checks++; if (o_done_sid !== 3'd3 || o_done_f !== 1'b1) begin failures++; $display("FAIL t1_sidf got sid=%0d f=%b exp 3 1", o_done_sid, o_done_f); end
        checks++; if (o_idle !== 1'b1) begin failures++; $display("FAIL t1_idle got=%b exp=1", o_idle); end
        @(posedge clk); #1;
        checks++; if (o_done_v !== 1'b0) begin failures++; $display("FAIL t1_done_pulse got=%b exp=0", o_done_v); end
    endtask

    task automatic test_credits();
        logic r, v, dv, dok; logic [4:0] pt, dt;
        for (int k = 0; k < 6; k++) begin
            do_issue(5'h10 + 5'(k), 10'd64, 65'h2000 + 65'(k), r, v, pt);
            if (k < 4) begin
                checks++; if (r !== 1'b1 || v !== 1'b1 || pt !== 5'(k)) begin failures++; $display("FAIL t2_issue%0d got r=%b v=%b tag=%0d exp 1 1 %0d", k, r, v, pt, k); end
            end else begin
                checks++; if (r !== 1'b0 || v !== 1'b0) begin failures++; $display("FAIL t2_block%0d got r=%b v=%b exp 0 0", k, r, v); end
            end
        end
        // response on tag 2 while entry 4 still waits; no same-cycle pop
        i_cmd_v = 1'b1; i_cmd_tag = 5'h14;
        i_rsp_v = 1'b1; i_rsp_tag = 5'd2; i_rsp_code = 8'h00;
        #1;
        checks++; if (o_cmd_r !== 1'b0) begin failures++; $display("FAIL t2_no_comb_path got=%b exp=0", o_cmd_r); end
        @(posedge clk); #1;
        i_rsp_v = 1'b0;
        checks++; if (o_done_v !== 1'b1 || o_done_tag !== 5'h12) begin failures++; $display("FAIL t2_done got v=%b tag=%h exp 1 12", o_done_v, o_done_tag); end
        checks++; if (o_cmd_r !== 1'b1) begin failures++; $display("FAIL t2_reenable got=%b exp=1", o_cmd_r); end
        @(posedge clk); #1;
        i_cmd_v = 1'b0;
        checks++; if (o_psl_cmd_v !== 1'b1 || o_psl_cmd_tag !== 5'd2) begin failures++; $display("FAIL t2_fifth got v=%b tag=%0d exp 1 2", o_psl_cmd_v, o_psl_cmd_tag); end
        for (int k = 0; k < 4; k++) begin
            do_rsp(5'(k), 8'h00, dv, dt, dok);
            checks++; if (dv !== 1'b1) begin failures++; $display("FAIL t2_drain%0d got=%b exp=1", k, dv); end
        end
        checks++; if (o_idle !== 1'b1) begin failures++; $display("FAIL t2_idle got=%b exp=1", o_idle); end
    endtask

    task automatic test_simultaneous();
        logic r, v, dv, dok; logic [4:0] pt, dt;
        do_issue(5'h0A, 10'd16, 65'h3000, r, v, pt);
        do_issue(5'h0B, 10'd16, 65'h3040, r, v, pt);
        checks++; if (pt !== 5'd1) begin failures++; $display("FAIL t3_setup got=%0d exp=1", pt); end
        i_cmd_v = 1'b1; i_cmd_tag = 5'h0C;
        i_rsp_v = 1'b1; i_rsp_tag = 5'd1; i_rsp_code = 8'h00;
        #1;
        checks++; if (o_cmd_r !== 1'b1) begin failures++; $display("FAIL t3_pop got=%b exp=1", o_cmd_r); end
        @(posedge clk); #1;
        i_cmd_v = 1'b0; i_rsp_v = 1'b0;
        checks++; if (o_psl_cmd_v !== 1'b1 || o_psl_cmd_tag !== 5'd2) begin failures++; $display("FAIL t3_newtag got v=%b tag=%0d exp 1 2", o_psl_cmd_v, o_psl_cmd_tag); end
        checks++; if (o_done_v !== 1'b1 || o_done_tag !== 5'h0B) begin failures++; $display("FAIL t3_done got v=%b tag=%h exp 1 0b", o_done_v, o_done_tag); end
        do_issue(5'h0D, 10'd16, 65'h3080, r, v, pt);
        checks++; if (r !== 1'b1 || pt !== 5'd1) begin failures++; $display("FAIL t3_reuse got r=%b tag=%0d exp 1 1", r, pt); end
        // two credits remained after the net-zero cycle: one more issue, then blocked
        do_issue(5'h0E, 10'd16, 65'h30C0, r, v, pt);
        checks++; if (r !== 1'b1 || pt !== 5'd3) begin failures++; $display("FAIL t3_last got r=%b tag=%0d exp 1 3", r, pt); end
        do_issue(5'h0F, 10'd16, 65'h3100, r, v, pt);
        checks++; if (r !== 1'b0) begin failures++; $display("FAIL t3_nocredit got=%b exp=0", r); end
        for (int k = 0; k < 4; k++) begin
            do_rsp(5'(k), 8'h00, dv, dt, dok);
            checks++; if (dv !== 1'b1) begin failures++; $display("FAIL t3_drain%0d got=%b exp=1", k, dv); end
        end
        checks++; if (o_idle !== 1'b1) begin failures++; $display("FAIL t3_idle got=%b exp=1", o_idle); end
    endtask

    task automatic test_fail_code();
        logic r, v, dv, dok; logic [4:0] pt, dt;
        do_issue(5'h1E, 10'd32, 65'h4000, r, v, pt);
        do_rsp(5'd0, 8'h05, dv, dt, dok);
        checks++; if (dv !== 1'b1 || dt !== 5'h1E || dok !== 1'b0) begin failures++; $display("FAIL t4_done got v=%b tag=%h ok=%b exp 1 1e 0", dv, dt, dok); end
        checks++; if (o_idle !== 1'b1) begin failures++; $display("FAIL t4_freed got=%b exp=1", o_idle); end
        do_issue(5'h1F, 10'd32, 65'h4040, r, v, pt);
        checks++; if (pt !== 5'd0) begin failures++; $display("FAIL t4_realloc got=%0d exp=0", pt); end
        do_rsp(5'd0, 8'h00, dv, dt, dok);
        checks++; if (dok !== 1'b1 || dt !== 5'h1F) begin failures++; $display("FAIL t4_ok got ok=%b tag=%h exp 1 1f", dok, dt); end
    endtask

    task automatic test_unexpected();
        logic r, v, dv, dok; logic [4:0] pt, dt;
        checks++; if (o_err_unexp_rsp !== 1'b0) begin failures++; $display("FAIL t5_pre got=%b exp=0", o_err_unexp_rsp); end
        do_rsp(5'd7, 8'h00, dv, dt, dok);
        checks++; if (dv !== 1'b0) begin failures++; $display("FAIL t5_nodone got=%b exp=0", dv); end
        checks++; if (o_err_unexp_rsp !== 1'b1) begin failures++; $display("FAIL t5_err got=%b exp=1", o_err_unexp_rsp); end
        checks++; if (o_idle !== 1'b1) begin failures++; $display("FAIL t5_sat_idle got=%b exp=1", o_idle); end
        do_issue(5'h05, 10'd8, 65'h5000, r, v, pt);
        do_rsp(5'd0, 8'h00, dv, dt, dok);
        checks++; if (o_err_unexp_rsp !== 1'b1 || dv !== 1'b1) begin failures++; $display("FAIL t5_sticky got err=%b dv=%b exp 1 1", o_err_unexp_rsp, dv); end
    endtask

    task automatic test_tag_exhaust();
        c2_v = 1'b1; i_cmd_tag = 5'h08;
        #1;
        checks++; if (b_cmd_r !== 1'b1) begin failures++; $display("FAIL tx_pop0 got=%b exp=1", b_cmd_r); end
        @(posedge clk); #1;
        checks++; if (b_cmd_v !== 1'b1 || b_cmd_tag !== 1'b0 || b_cmd_r !== 1'b1) begin failures++; $display("FAIL tx_tag0 got v=%b tag=%b r=%b exp 1 0 1", b_cmd_v, b_cmd_tag, b_cmd_r); end
        i_cmd_tag = 5'h09;
        @(posedge clk); #1;
        checks++; if (b_cmd_tag !== 1'b1 || b_cmd_r !== 1'b0) begin failures++; $display("FAIL tx_full got tag=%b r=%b exp 1 0", b_cmd_tag, b_cmd_r); end
        r2_v = 1'b1; r2_tag = 1'b0; i_rsp_code = 8'h00;
        @(posedge clk); #1;
        r2_v = 1'b0;
        checks++; if (b_done_v !== 1'b1 || b_done_tag !== 5'h08 || b_cmd_r !== 1'b1) begin failures++; $display("FAIL tx_free got dv=%b dtag=%h r=%b exp 1 08 1", b_done_v, b_done_tag, b_cmd_r); end
        @(posedge clk); #1;
        c2_v = 1'b0;
        checks++; if (b_cmd_v !== 1'b1 || b_cmd_tag !== 1'b0) begin failures++; $display("FAIL tx_reuse got v=%b tag=%b exp 1 0", b_cmd_v, b_cmd_tag); end
    endtask

    task automatic test_reset_midop();
        logic r, v; logic [4:0] pt;
        do_issue(5'h01, 10'd4, 65'h6000, r, v, pt);
        do_issue(5'h02, 10'd4, 65'h6040, r, v, pt);
        do_issue(5'h03, 10'd4, 65'h6080, r, v, pt);
        checks++; if (v !== 1'b1 || pt !== 5'd2) begin failures++; $display("FAIL t6_setup got v=%b tag=%0d exp 1 2", v, pt); end
        reset = 1'b0;
        #1;
        checks++; if (o_psl_cmd_v !== 1'b0 || o_psl_cmd_tag !== 5'd0 || o_done_v !== 1'b0) begin failures++; $display("FAIL t6_async got v=%b tag=%0d dv=%b exp 0 0 0", o_psl_cmd_v, o_psl_cmd_tag, o_done_v); end
        checks++; if (o_idle !== 1'b1 || o_err_unexp_rsp !== 1'b0) begin failures++; $display("FAIL t6_state got idle=%b err=%b exp 1 0", o_idle, o_err_unexp_rsp); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (o_idle !== 1'b1 || o_done_v !== 1'b0) begin failures++; $display("FAIL t6_release got idle=%b dv=%b exp 1 0", o_idle, o_done_v); end
        for (int k = 0; k < 4; k++) begin
            do_issue(5'(k), 10'd4, 65'h7000, r, v, pt);
            checks++; if (r !== 1'b1 || pt !== 5'(k)) begin failures++; $display("FAIL t6_full%0d got r=%b tag=%0d exp 1 %0d", k, r, pt, k); end
        end
        do_issue(5'h04, 10'd4, 65'h7000, r, v, pt);
        checks++; if (r !== 1'b0) begin failures++; $display("FAIL t6_limit got=%b exp=0", r); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_credits();
        test_simultaneous();
        test_fail_code();
        test_unexpected();
        test_tag_exhaust();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
